// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings and control bundle for the RV32I pipeline control unit
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    RES_ALU   = 3'd0,
    RES_MEM   = 3'd1,
    RES_PC4   = 3'd2,
    RES_IMM   = 3'd3,
    RES_PCIMM = 3'd4
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_write;
    logic               is_load;
    logic               branch;
    logic               jump;
    logic               alu_src;
    logic               uses_rs1;
    logic               uses_rs2;
    alu_ctrl_e          alu_control;
    result_src_e        result_src;
    logic [2:0]         funct3;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

  // True when bundle p will write a nonzero register that equals rs.
  function automatic logic writes_to(input ctrl_bundle_t p, input logic [REG_W-1:0] rs);
    return p.valid && p.reg_write && (p.rd != '0) && (p.rd == rs);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - ID-stage opcode/funct decode into a control bundle
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  input  logic         valid,
  output ctrl_bundle_t bundle,
  output imm_src_e     imm_src,
  output logic         unknown_op
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign alt          = instr[30];
  assign unused_instr = ^{instr[31], instr[29:25]};

  function automatic alu_ctrl_e alu_op(input logic [2:0] f3, input logic sub_sra);
    case (f3)
      3'b000:  return sub_sra ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return sub_sra ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Branch comparisons reuse the subtract/set-less-than paths.
  function automatic alu_ctrl_e branch_op(input logic [2:0] f3);
    case (f3[2:1])
      2'b10:   return ALU_SLT;
      2'b11:   return ALU_SLTU;
      default: return ALU_SUB;
    endcase
  endfunction

  always_comb begin
    bundle        = BUBBLE;
    imm_src       = IMM_I;
    unknown_op    = 1'b0;
    bundle.funct3 = funct3;
    bundle.rd     = instr[11:7];
    bundle.rs1    = instr[19:15];
    bundle.rs2    = instr[24:20];
    case (opcode)
      OP_R: begin
        bundle.reg_write   = 1'b1;
        bundle.uses_rs1    = 1'b1;
        bundle.uses_rs2    = 1'b1;
        bundle.alu_control = alu_op(funct3, alt);
      end
      OP_I: begin
        bundle.reg_write   = 1'b1;
        bundle.uses_rs1    = 1'b1;
        bundle.alu_src     = 1'b1;
        bundle.alu_control = alu_op(funct3, alt && (funct3 == 3'b101));
      end
      OP_LOAD: begin
        bundle.reg_write  = 1'b1;
        bundle.is_load    = 1'b1;
        bundle.uses_rs1   = 1'b1;
        bundle.alu_src    = 1'b1;
        bundle.result_src = RES_MEM;
      end
      OP_STORE: begin
        bundle.mem_write = 1'b1;
        bundle.uses_rs1  = 1'b1;
        bundle.uses_rs2  = 1'b1;
        bundle.alu_src   = 1'b1;
        imm_src          = IMM_S;
      end
      OP_BRANCH: begin
        bundle.branch      = 1'b1;
        bundle.uses_rs1    = 1'b1;
        bundle.uses_rs2    = 1'b1;
        bundle.alu_control = branch_op(funct3);
        imm_src            = IMM_B;
      end
      OP_JAL: begin
        bundle.reg_write  = 1'b1;
        bundle.jump       = 1'b1;
        bundle.result_src = RES_PC4;
        imm_src           = IMM_J;
      end
      OP_JALR: begin
        bundle.reg_write  = 1'b1;
        bundle.jump       = 1'b1;
        bundle.uses_rs1   = 1'b1;
        bundle.alu_src    = 1'b1;
        bundle.result_src = RES_PC4;
      end
      OP_LUI: begin
        bundle.reg_write   = 1'b1;
        bundle.alu_src     = 1'b1;
        bundle.alu_control = ALU_PASSB;
        bundle.result_src  = RES_IMM;
        imm_src            = IMM_U;
      end
      OP_AUIPC: begin
        bundle.reg_write  = 1'b1;
        bundle.alu_src    = 1'b1;
        bundle.result_src = RES_PCIMM;
        imm_src           = IMM_U;
      end
      default: unknown_op = 1'b1;
    endcase

    // Zero unused register fields so hazard/forward compares never see immediate bits.
    if (bundle.rd == '0) bundle.reg_write = 1'b0;
    if (!bundle.reg_write) bundle.rd = '0;
    if (!bundle.uses_rs1) bundle.rs1 = '0;
    if (!bundle.uses_rs2) bundle.rs2 = '0;
    bundle.valid = valid && !unknown_op;
    if (!bundle.valid) bundle = BUBBLE;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage control pipeline with stall, flush and forwarding generation
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 4,
  parameter int FWD_EN     = 1,
  parameter int IMM_SRC_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           id_instr,
  input  logic                  id_valid,
  input  logic                  ex_redirect,
  output logic [IMM_SRC_W-1:0]  id_imm_src,
  output logic                  id_illegal,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [ALU_CTRL_W-1:0] ex_alu_control,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic [2:0]            ex_funct3,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mem_mem_write,
  output logic [2:0]            mem_funct3,
  output logic [2:0]            wb_result_src,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  localparam bit FWD = (FWD_EN != 0);

  ctrl_bundle_t id_bundle;
  ctrl_bundle_t ex_d, ex_q;
  ctrl_bundle_t mem_d, mem_q;
  ctrl_bundle_t wb_d, wb_q;
  imm_src_e     id_imm;
  logic         id_unknown;
  logic         ld_hit, raw_hit, hazard;
  logic         unused_bits;

  ctrl_decode u_decode (
    .instr      (id_instr),
    .valid      (id_valid),
    .bundle     (id_bundle),
    .imm_src    (id_imm),
    .unknown_op (id_unknown)
  );

  always_comb begin
    ld_hit  = ex_q.is_load &&
              ((id_bundle.uses_rs1 && writes_to(ex_q, id_bundle.rs1)) ||
               (id_bundle.uses_rs2 && writes_to(ex_q, id_bundle.rs2)));
    // Without forwarding, wait until the producer reaches WB (write-before-read regfile).
    raw_hit = (id_bundle.uses_rs1 && (writes_to(ex_q, id_bundle.rs1) || writes_to(mem_q, id_bundle.rs1))) ||
              (id_bundle.uses_rs2 && (writes_to(ex_q, id_bundle.rs2) || writes_to(mem_q, id_bundle.rs2)));
    hazard  = id_bundle.valid && (FWD ? ld_hit : raw_hit);
  end

  always_comb begin
    stall_f = hazard && !ex_redirect && !rst;
    stall_d = stall_f;
    flush_d = ex_redirect && !rst;
    flush_e = (hazard || ex_redirect) && !rst;
  end

  always_comb begin
    ex_d  = (flush_e || !id_valid) ? BUBBLE : id_bundle;
    mem_d = ex_q;
    wb_d  = mem_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // MEM result is younger than WB, so it wins when both match.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD) begin
      if (writes_to(mem_q, ex_q.rs1))     fwd_a = 2'b10;
      else if (writes_to(wb_q, ex_q.rs1)) fwd_a = 2'b01;
      if (writes_to(mem_q, ex_q.rs2))     fwd_b = 2'b10;
      else if (writes_to(wb_q, ex_q.rs2)) fwd_b = 2'b01;
    end
  end

  assign id_imm_src     = id_imm;
  assign id_illegal     = id_valid && id_unknown && !rst;
  assign ex_alu_control = ex_q.alu_control;
  assign ex_alu_src     = ex_q.alu_src;
  assign ex_branch      = ex_q.branch;
  assign ex_jump        = ex_q.jump;
  assign ex_funct3      = ex_q.funct3;
  assign ex_rs1         = ex_q.rs1;
  assign ex_rs2         = ex_q.rs2;
  assign mem_mem_write  = mem_q.mem_write;
  assign mem_funct3     = mem_q.funct3;
  assign wb_result_src  = wb_q.result_src;
  assign wb_reg_write   = wb_q.reg_write;
  assign wb_rd          = wb_q.rd;
  assign unused_bits    = ^{ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam logic [31:0] ADD3   = 32'h002081B3;
  localparam logic [31:0] SUB4   = 32'h40118233;
  localparam logic [31:0] LW5    = 32'h0000A283;
  localparam logic [31:0] ADD6   = 32'h00228333;
  localparam logic [31:0] JAL1   = 32'h008000EF;
  localparam logic [31:0] ADDX0W = 32'h00208033;
  localparam logic [31:0] ADDX0R = 32'h00200333;
  localparam logic [31:0] LWX0   = 32'h0000A003;
  localparam logic [31:0] ADD6X0 = 32'h00000333;
  localparam logic [31:0] ILL    = 32'hFFFFFFFF;
  localparam logic [31:0] SW5    = 32'h0050A223;
  localparam logic [31:0] LUI5   = 32'h123452B7;
  localparam logic [31:0] AUIPC6 = 32'h00001317;

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic       br;
    logic       jp;
    logic [3:0] alu;
    logic [2:0] rs;
    logic [4:0] rd;
    logic [2:0] imm;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] id_instr, id_instr_1;
  logic id_valid, ex_redirect, id_valid_1, ex_redirect_1;
  logic [2:0] id_imm_src, id_imm_src_1;
  logic id_illegal, stall_f, stall_d, flush_d, flush_e;
  logic id_illegal_1, stall_f_1, stall_d_1, flush_d_1, flush_e_1;
  logic [3:0] ex_alu_control, ex_alu_control_1;
  logic ex_alu_src, ex_branch, ex_jump, ex_alu_src_1, ex_branch_1, ex_jump_1;
  logic [2:0] ex_funct3, mem_funct3, wb_result_src, ex_funct3_1, mem_funct3_1, wb_result_src_1;
  logic [4:0] ex_rs1, ex_rs2, wb_rd, ex_rs1_1, ex_rs2_1, wb_rd_1;
  logic [1:0] fwd_a, fwd_b, fwd_a_1, fwd_b_1;
  logic mem_mem_write, wb_reg_write, mem_mem_write_1, wb_reg_write_1;
  logic unused_tb;
  assign unused_tb = ^{ex_funct3, mem_funct3, ex_rs2, ex_funct3_1, mem_funct3_1, wb_result_src_1,
                       ex_rs2_1, id_imm_src_1, id_illegal_1, flush_d_1, ex_alu_src_1, ex_branch_1,
                       ex_jump_1, mem_mem_write_1};

  pipe_hazard_ctrl #(.FWD_EN(1)) u_dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .ex_redirect(ex_redirect),
    .id_imm_src(id_imm_src), .id_illegal(id_illegal), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .ex_alu_control(ex_alu_control), .ex_alu_src(ex_alu_src),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_mem_write(mem_mem_write), .mem_funct3(mem_funct3),
    .wb_result_src(wb_result_src), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd)
  );

  pipe_hazard_ctrl #(.FWD_EN(0)) u_dut_nofwd (
    .clk(clk), .rst(rst), .id_instr(id_instr_1), .id_valid(id_valid_1), .ex_redirect(ex_redirect_1),
    .id_imm_src(id_imm_src_1), .id_illegal(id_illegal_1), .stall_f(stall_f_1), .stall_d(stall_d_1),
    .flush_d(flush_d_1), .flush_e(flush_e_1), .ex_alu_control(ex_alu_control_1), .ex_alu_src(ex_alu_src_1),
    .ex_branch(ex_branch_1), .ex_jump(ex_jump_1), .ex_funct3(ex_funct3_1), .ex_rs1(ex_rs1_1), .ex_rs2(ex_rs2_1),
    .fwd_a(fwd_a_1), .fwd_b(fwd_b_1), .mem_mem_write(mem_mem_write_1), .mem_funct3(mem_funct3_1),
    .wb_result_src(wb_result_src_1), .wb_reg_write(wb_reg_write_1), .wb_rd(wb_rd_1)
  );

  int   nvec = 0;
  int   nerr = 0;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return alt ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] ins);
    exp_t e;
    e    = '0;
    e.rd = ins[11:7];
    case (ins[6:0])
      7'h33: begin e.rw = 1'b1; e.alu = alu_ref(ins[14:12], ins[30]); end
      7'h13: begin e.rw = 1'b1; e.alu = alu_ref(ins[14:12], ins[30] && ins[14:12] == 3'd5); end
      7'h03: begin e.rw = 1'b1; e.rs = 3'd1; end
      7'h23: begin e.mw = 1'b1; e.imm = 3'd1; end
      7'h6F: begin e.rw = 1'b1; e.jp = 1'b1; e.rs = 3'd2; e.imm = 3'd3; end
      7'h67: begin e.rw = 1'b1; e.jp = 1'b1; e.rs = 3'd2; end
      7'h37: begin e.rw = 1'b1; e.alu = 4'd10; e.rs = 3'd3; e.imm = 3'd4; end
      7'h17: begin e.rw = 1'b1; e.rs = 3'd4; e.imm = 3'd4; end
      default: e = '0;
    endcase
    if (e.rd == 5'd0) e.rw = 1'b0;
    if (!e.rw) e.rd = 5'd0;
    return e;
  endfunction

  task automatic sb_check();
    exp_t b;
    b = sbq[$];
    chk("ex_alu_control", 32'(ex_alu_control), 32'(b.alu));
    chk("ex_branch", 32'(ex_branch), 32'(b.br));
    chk("ex_jump", 32'(ex_jump), 32'(b.jp));
    if (sbq.size() >= 2) chk("mem_mem_write", 32'(mem_mem_write), 32'(sbq[sbq.size()-2].mw));
    if (sbq.size() == 3) begin
      b = sbq.pop_front();
      chk("wb_reg_write", 32'(wb_reg_write), 32'(b.rw));
      chk("wb_rd", 32'(wb_rd), 32'(b.rd));
      chk("wb_result_src", 32'(wb_result_src), 32'(b.rs));
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic v, input logic redir,
                      input logic xs, input logic xfd, input logic xfe, input logic xill);
    exp_t e;
    id_instr    = ins;
    id_valid    = v;
    ex_redirect = redir;
    #1;
    e = ref_dec(ins);
    chk("stall_f", 32'(stall_f), 32'(xs));
    chk("stall_d", 32'(stall_d), 32'(xs));
    chk("flush_d", 32'(flush_d), 32'(xfd));
    chk("flush_e", 32'(flush_e), 32'(xfe));
    chk("id_illegal", 32'(id_illegal), 32'(xill));
    chk("id_imm_src", 32'(id_imm_src), 32'(e.imm));
    sbq.push_back((v && !xfe) ? e : exp_t'('0));
    @(posedge clk);
    @(negedge clk);
    sb_check();
  endtask

  task automatic sb_reset();
    sbq.delete();
    sbq.push_back(exp_t'('0));
    sbq.push_back(exp_t'('0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    id_instr = $urandom; id_valid = 1'b1; ex_redirect = 1'b1;
    id_instr_1 = $urandom; id_valid_1 = 1'b1; ex_redirect_1 = 1'b1;
    @(posedge clk); @(negedge clk);
    id_instr = $urandom; id_instr_1 = $urandom;
    @(posedge clk); @(negedge clk);
    chk("reset_outputs", 32'({stall_f, stall_d, flush_d, flush_e, id_illegal, fwd_a, fwd_b, ex_alu_control,
        ex_branch, ex_jump, ex_alu_src, mem_mem_write, wb_reg_write, wb_rd, ex_rs1}), 32'd0);
    chk("reset_outputs_nofwd", 32'({stall_f_1, stall_d_1, flush_d_1, flush_e_1, id_illegal_1, fwd_a_1, fwd_b_1,
        ex_alu_control_1, ex_branch_1, ex_jump_1, ex_alu_src_1, mem_mem_write_1, wb_reg_write_1, wb_rd_1}), 32'd0);
    rst = 1'b0; id_valid = 1'b0; ex_redirect = 1'b0;
    id_valid_1 = 1'b0; ex_redirect_1 = 1'b0;
    sb_reset();

    // add feeding sub through the EX/MEM path
    step(ADD3, 1, 0, 0, 0, 0, 0);
    step(SUB4, 1, 0, 0, 0, 0, 0);
    chk("fwd_a_exmem", 32'(fwd_a), 32'd2);
    chk("fwd_b_exmem", 32'(fwd_b), 32'd0);
    chk("ex_rs1_sub", 32'(ex_rs1), 32'd3);
    step(32'd0, 0, 0, 0, 0, 0, 0);

    // load-use: one stall cycle, then MEM/WB forward
    step(LW5, 1, 0, 0, 0, 0, 0);
    step(ADD6, 1, 0, 1, 0, 1, 0);
    step(ADD6, 1, 0, 0, 0, 0, 0);
    chk("fwd_a_memwb", 32'(fwd_a), 32'd1);
    chk("fwd_b_memwb", 32'(fwd_b), 32'd0);

    // load-use coincident with redirect, then redirect over a jal
    step(LW5, 1, 0, 0, 0, 0, 0);
    step(ADD6, 1, 1, 0, 1, 1, 0);
    chk("redir_ex_rs1", 32'(ex_rs1), 32'd0);
    step(JAL1, 1, 1, 0, 1, 1, 0);
    step(JAL1, 1, 0, 0, 0, 0, 0);

    // x0 writers never forward or stall
    step(ADDX0W, 1, 0, 0, 0, 0, 0);
    step(ADDX0R, 1, 0, 0, 0, 0, 0);
    chk("fwd_a_x0", 32'(fwd_a), 32'd0);
    step(LWX0, 1, 0, 0, 0, 0, 0);
    step(ADD6X0, 1, 0, 0, 0, 0, 0);

    // illegal opcode, remaining formats, and load-use on a store's rs2
    step(ILL, 1, 0, 0, 0, 0, 1);
    step(SW5, 1, 0, 0, 0, 0, 0);
    step(LUI5, 1, 0, 0, 0, 0, 0);
    step(AUIPC6, 1, 0, 0, 0, 0, 0);
    step(LW5, 1, 0, 0, 0, 0, 0);
    step(SW5, 1, 0, 1, 0, 1, 0);
    step(SW5, 1, 0, 0, 0, 0, 0);
    repeat (3) step(32'd0, 0, 0, 0, 0, 0, 0);

    // reset mid-stream discards in-flight bundles
    step(SW5, 1, 0, 0, 0, 0, 0);
    step(SUB4, 1, 0, 0, 0, 0, 0);
    id_instr = ADD3; id_valid = 1'b1; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("midrst_ex_alu", 32'(ex_alu_control), 32'd0);
    chk("midrst_mem_write", 32'(mem_mem_write), 32'd0);
    rst = 1'b0; id_valid = 1'b0;
    sb_reset();
    step(ADD3, 1, 0, 0, 0, 0, 0);
    repeat (3) step(32'd0, 0, 0, 0, 0, 0, 0);

    // no-forwarding build: RAW resolved by a two-cycle stall
    id_instr_1 = ADD3; id_valid_1 = 1'b1;
    #1 chk("nofwd_stall_c0", 32'(stall_f_1), 32'd0);
    @(posedge clk); @(negedge clk);
    id_instr_1 = SUB4;
    #1 chk("nofwd_stall_c1", 32'({stall_f_1, stall_d_1, flush_e_1}), 32'd7);
    @(posedge clk); @(negedge clk);
    #1 chk("nofwd_stall_c2", 32'({stall_f_1, stall_d_1, flush_e_1}), 32'd7);
    @(posedge clk); @(negedge clk);
    #1 chk("nofwd_stall_c3", 32'(stall_f_1), 32'd0);
    chk("nofwd_ex_bubble", 32'(ex_rs1_1), 32'd0);
    chk("nofwd_wb_add", 32'({wb_reg_write_1, wb_rd_1}), 32'h23);
    @(posedge clk); @(negedge clk);
    id_valid_1 = 1'b0;
    #1 chk("nofwd_ex_sub", 32'({ex_alu_control_1, ex_rs1_1}), 32'({4'd1, 5'd3}));
    chk("nofwd_fwd", 32'({fwd_a_1, fwd_b_1}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipelined control unit for the 5-stage RV32I core. It decodes the ID-stage instruction into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It also generates load-use and RAW stall signals, branch/jump flush signals and EX-operand forwarding selects. The fetch/decode datapath consumes the stall and flush outputs; the ALU, memory and writeback stages consume the per-stage controls.

Parameters:
REG_ADDR_W, 5, register index width
ALU_CTRL_W, 4, ALU control width (encodings in package)
FWD_EN, 1, 1 = forwarding enabled; 0 = no forwarding, RAW resolved by stalling
IMM_SRC_W, 3, immediate-format select width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_instr  in  32  instruction in ID
id_valid  in  1  ID instruction valid
ex_redirect  in  1  taken branch/jump resolved in EX
id_imm_src  out  IMM_SRC_W  imm format for ID imm-gen (I/S/B/J/U)
id_illegal  out  1  unknown opcode in ID
stall_f, stall_d  out  1 each  hold PC / IF-ID register
flush_d, flush_e  out  1 each  bubble IF-ID / ID-EX register
ex_alu_control  out  ALU_CTRL_W
ex_alu_src, ex_branch, ex_jump  out  1 each
ex_funct3  out  3
ex_rs1, ex_rs2  out  REG_ADDR_W
fwd_a, fwd_b  out  2  00 regfile, 10 EX/MEM result, 01 MEM/WB result
mem_mem_write  out  1
mem_funct3  out  3
wb_result_src  out  3  000 ALU, 001 mem, 010 PC+4, 011 imm, 100 PC+imm
wb_reg_write  out  1
wb_rd  out  REG_ADDR_W

Behaviour:
- Decode (combinational, ID): R, I-ALU, load, store, branch, jal, jalr, lui, auipc.
  - Any other opcode -> id_illegal=1; bundle is treated as a bubble (no reg/mem write, no branch/jump).
- rd==0 forces reg_write=0 in the bundle.
- uses_rs1 = R/I/load/store/branch/jalr. uses_rs2 = R/store/branch.
- Every bundle field carries a valid bit. Each stage register updates every cycle unless noted.
- Latency: an ID bundle appears on the ex_* outputs 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later.
- Reset: all stage registers cleared (valid=0, reg_write=0, mem_write=0, branch=0, jump=0, all other fields 0). Outputs follow: fwd_a=fwd_b=00, all stall/flush signals 0. Reset applied mid-stream discards in-flight bundles.
- Load-use hazard (FWD_EN=1): id_valid & ex_valid & ex_is_load & ex_rd!=0 & matching used rs.
  - Action: stall_f=stall_d=1, flush_e=1; ID/EX loads a bubble and the IF-ID contents are held.
- RAW hazard (FWD_EN=0): stall if any used rs matches the rd of a valid reg-writing bundle in EX or MEM.
  - Regfile is write-before-read, so WB needs no stall. fwd_a=fwd_b=00 always.
- Forwarding (FWD_EN=1), per EX operand:
  - 10 if mem valid & reg_write & mem_rd!=0 & mem_rd==ex_rsN;
  - else 01 if the same conditions hold for WB;
  - else 00.
  - MEM has priority over WB.
- Redirect: ex_redirect=1 -> flush_d=1, flush_e=1; the next ID/EX and IF-ID contents are bubbles.
  - Redirect has priority over any stall: stall_f=stall_d=0 in that cycle.
- Bubble insertion never blocks EX->MEM->WB advancement.
- id_valid=0 -> ID/EX loads a bubble and no stall is raised.

Decomposition:
- Package pipe_ctrl_pkg: opcode constants, ALU control encodings (ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, PASSB 10), ResultSrc and ImmSrc encodings, and a packed control-bundle struct.
- Sub-module ctrl_decode: combinational opcode/funct decode to bundle. Instantiated once in ID.
- Hazard and forwarding logic stays in the top module.

Test Plan:
- Reset held 2 cycles with random id_instr -> all outputs 0 and fwd=00. The first valid add reaches wb_reg_write=1 exactly 3 cycles after entering ID.
- 0x002081B3 (add x3,x1,x2) then 0x40118233 (sub x4,x3,x1) -> while sub is in EX: fwd_a=10, fwd_b=00, ex_alu_control=SUB, no stall.
- 0x0000A283 (lw x5,0(x1)) then 0x00228333 (add x6,x5,x2) -> stall_f=stall_d=flush_e=1 for exactly 1 cycle; next cycle add is in EX with fwd_a=01, fwd_b=00.
- Load-use hazard coincident with ex_redirect=1 -> stall_f=stall_d=0, flush_d=flush_e=1; the following EX holds a bubble (ex_branch=ex_jump=mem_mem_write=0).
- Writer add x0,x1,x2 followed by reader add x6,x0,x2 -> fwd_a=00 and wb_reg_write=0 for the x0 writer. Opcode 0x7F -> id_illegal=1 and the bubble produces no writes.
- FWD_EN=0: add x3,x1,x2 then sub x4,x3,x1 -> stall asserted 2 consecutive cycles; sub enters EX 3 cycles after add with fwd_a=fwd_b=00.
